// File: rtl/aes_axis_cmd_loader.sv
// AXI-Stream command/key/block collector that feeds aes_top with one-cycle start strobes.
// Optional build macro AES_TLAST_CHECK_EN enforces tlast on exactly the last frame word.
module aes_axis_cmd_loader #(
  parameter int WORD_S    = 32,
  parameter int KEY_S     = 128,
  parameter int BLK_S     = 128,
  parameter int KEY_WORDS = KEY_S / WORD_S,
  parameter int BLK_WORDS = BLK_S / WORD_S,
  parameter int TIMEOUT   = 64,
  parameter logic [WORD_S-1:0] CMD_SET_KEY_128     = 32'h0000_0001,
  parameter logic [WORD_S-1:0] CMD_ECB_ENCRYPT_128 = 32'h0000_0002,
  parameter logic [WORD_S-1:0] CMD_ECB_DECRYPT_128 = 32'h0000_0003
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_S-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [0:WORD_S-1] aes_cmd,
  output logic [0:KEY_S-1]  aes_key,
  output logic [0:BLK_S-1]  aes_in_blk,
  output logic              en,
  input  logic              en_o,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam int MAX_WORDS = (KEY_WORDS > BLK_WORDS) ? KEY_WORDS : BLK_WORDS;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEY   = 3'd1,
    BLK   = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   word_cnt, word_cnt_n;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;
  logic [0:WORD_S-1]  cmd_n;
  logic [0:KEY_S-1]   key_n;
  logic [0:BLK_S-1]   blk_n;
  logic               err_n;
  logic               err_set;
  logic               accept;
  logic               last_word;

  // tready is gated by reset_n so it reads 0 while reset is held
  assign s_axis_tready = reset_n && (state == IDLE || state == KEY || state == BLK);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign en            = (state == ISSUE);
  assign busy          = (state != IDLE);
  assign last_word     = (state == KEY) ? (word_cnt == CNT_W'(KEY_WORDS - 1))
                                        : (word_cnt == CNT_W'(BLK_WORDS - 1));

`ifndef AES_TLAST_CHECK_EN
  logic tlast_unused;
  assign tlast_unused = s_axis_tlast;
`endif

  always_comb begin
    state_n    = state;
    word_cnt_n = word_cnt;
    tmo_cnt_n  = tmo_cnt;
    cmd_n      = aes_cmd;
    key_n      = aes_key;
    blk_n      = aes_in_blk;
    err_set    = 1'b0;

    case (state)
      IDLE: begin
        word_cnt_n = '0;
        tmo_cnt_n  = '0;
        if (accept) begin
          cmd_n = s_axis_tdata;
          if (s_axis_tdata == CMD_SET_KEY_128) begin
            state_n = KEY;
          end else if (s_axis_tdata == CMD_ECB_ENCRYPT_128 ||
                       s_axis_tdata == CMD_ECB_DECRYPT_128) begin
            state_n = BLK;
            key_n   = '0;
          end else begin
            err_set = 1'b1;
          end
`ifdef AES_TLAST_CHECK_EN
          if (s_axis_tlast) begin
            err_set = 1'b1;
            state_n = IDLE;
          end
`endif
        end
      end

      KEY, BLK: begin
        if (accept) begin
          // word n lands at bits [32n +: 32], so the first word is the most significant
          if (state == KEY) begin
            for (int n = 0; n < KEY_WORDS; n++)
              if (word_cnt == CNT_W'(n)) key_n[n*WORD_S +: WORD_S] = s_axis_tdata;
          end else begin
            for (int n = 0; n < BLK_WORDS; n++)
              if (word_cnt == CNT_W'(n)) blk_n[n*WORD_S +: WORD_S] = s_axis_tdata;
          end
          if (last_word) begin
            state_n    = ISSUE;
            word_cnt_n = '0;
          end else begin
            word_cnt_n = word_cnt + 1'b1;
          end
`ifdef AES_TLAST_CHECK_EN
          if (s_axis_tlast != last_word) begin
            err_set    = 1'b1;
            state_n    = IDLE;
            word_cnt_n = '0;
          end
`endif
        end
      end

      ISSUE: begin
        tmo_cnt_n = '0;
        state_n   = en_o ? IDLE : WAIT;
      end

      WAIT: begin
        if (en_o) begin
          state_n = IDLE;
        end else if (TIMEOUT > 0) begin
          if (tmo_cnt == TMO_LAST) begin
            err_set = 1'b1;
            state_n = IDLE;
          end else begin
            tmo_cnt_n = tmo_cnt + 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    // a new error in the same cycle beats a clear request
    err_n = err;
    if (err_clr) err_n = 1'b0;
    if (err_set) err_n = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      word_cnt   <= '0;
      tmo_cnt    <= '0;
      aes_cmd    <= '0;
      aes_key    <= '0;
      aes_in_blk <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      word_cnt   <= word_cnt_n;
      tmo_cnt    <= tmo_cnt_n;
      aes_cmd    <= cmd_n;
      aes_key    <= key_n;
      aes_in_blk <= blk_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_aes_axis_cmd_loader.sv
// Directed bench for aes_axis_cmd_loader: frame table plus reset, error and timeout sequences.
// Build with AES_TLAST_CHECK_EN defined to also exercise the early-tlast drop.
module tb_aes_axis_cmd_loader;

  localparam logic [31:0] C_SETKEY = 32'h0000_0001;
  localparam logic [31:0] C_ENC    = 32'h0000_0002;
  localparam logic [31:0] C_DEC    = 32'h0000_0003;
  localparam int          TMO      = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [0:31]  aes_cmd;
  logic [0:127] aes_key;
  logic [0:127] aes_in_blk;
  logic         en;
  logic         en_o;
  logic         busy;
  logic         err;
  logic         err_clr;

  aes_axis_cmd_loader #(
    .TIMEOUT            (TMO),
    .CMD_SET_KEY_128    (C_SETKEY),
    .CMD_ECB_ENCRYPT_128(C_ENC),
    .CMD_ECB_DECRYPT_128(C_DEC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .aes_cmd      (aes_cmd),
    .aes_key      (aes_key),
    .aes_in_blk   (aes_in_blk),
    .en           (en),
    .en_o         (en_o),
    .busy         (busy),
    .err          (err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  always @(negedge clk) if (en) en_cnt++;

  typedef struct {
    logic [31:0]  cmd;
    logic [127:0] data;
    int           gap;
    int           resp;     // cycles after ISSUE before en_o; -1 = never answer
    logic [127:0] exp_key;
    logic [127:0] exp_blk;
    bit           exp_err;
  } vec_t;

  localparam logic [127:0] K1 = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] K2 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] PT = 128'h54776F204F6E65204E696E652054776F;
  localparam logic [127:0] CT = 128'h29C3505F571420F6402299B31A02D73A;

  vec_t vecs[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input bit last);
    bit ok = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (s_axis_tready) ok = 1;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("word_accepted", ok, 1);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int start_en = en_cnt;
    int cyc;
    send_word(v.cmd, 1'b0);
    check($sformatf("v%0d_busy_after_cmd", idx), busy, 1);
    for (int n = 0; n < 4; n++) begin
      send_word(v.data[(3-n)*32 +: 32], n == 3);
      if (n < 3) repeat (v.gap) begin @(posedge clk); #1; end
    end
    check($sformatf("v%0d_en_after_last", idx), en, 1);
    check($sformatf("v%0d_tready_issue", idx), s_axis_tready, 0);
    if (v.resp >= 0) begin
      repeat (v.resp) begin
        @(posedge clk); #1;
        check($sformatf("v%0d_wait_stall", idx), {s_axis_tready, en}, 2'b00);
      end
      en_o = 1'b1;
      @(posedge clk); #1;
      en_o = 1'b0;
      check($sformatf("v%0d_idle_after_en_o", idx), {busy, s_axis_tready}, 2'b01);
    end else begin
      cyc = 0;
      while (!s_axis_tready && cyc < 50) begin @(posedge clk); #1; cyc++; end
      check($sformatf("v%0d_timeout_cycles", idx), cyc, TMO + 1);
    end
    check($sformatf("v%0d_en_pulses", idx), en_cnt - start_en, 1);
    check($sformatf("v%0d_key", idx), aes_key, v.exp_key);
    check($sformatf("v%0d_blk", idx), aes_in_blk, v.exp_blk);
    check($sformatf("v%0d_err", idx), err, v.exp_err);
    if (err) begin
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      check($sformatf("v%0d_err_clr", idx), err, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    vecs[0] = '{C_SETKEY, K1, 0, 2,  K1, 128'h0, 1'b0};
    vecs[1] = '{C_ENC,    PT, 0, 0,  '0, PT,     1'b0};
    vecs[2] = '{C_DEC,    CT, 0, 1,  '0, CT,     1'b0};
    vecs[3] = '{C_SETKEY, K2, 1, 3,  K2, CT,     1'b0};
    vecs[4] = '{C_ENC,    PT, 3, 0,  '0, PT,     1'b0};
    vecs[5] = '{C_ENC,    CT, 0, -1, '0, CT,     1'b1};
    vecs[6] = '{C_SETKEY, K1, 0, TMO, K1, CT,    1'b0};

    reset_n = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    en_o = 1'b0; err_clr = 1'b0;
    #23;
    check("rst_tready", s_axis_tready, 0);
    check("rst_ctrl", {en, busy, err}, 3'b000);
    check("rst_cmd", aes_cmd, 0);
    check("rst_key", aes_key, 0);
    check("rst_blk", aes_in_blk, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("tready_after_release", s_axis_tready, 1);
    @(posedge clk); #1;

    // unknown command: flagged and dropped, stays idle
    e0 = en_cnt;
    send_word(32'hDEADBEEF, 1'b0);
    check("bad_cmd_err", err, 1);
    check("bad_cmd_idle", {busy, s_axis_tready}, 2'b01);
    check("bad_cmd_no_en", en_cnt - e0, 0);
    err_clr = 1'b1;
    send_word(32'hDEADBEEF, 1'b0);
    check("set_beats_clr", err, 1);
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("err_clr", err, 0);

    for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

    // reset in the middle of a block
    send_word(C_ENC, 1'b0);
    send_word(PT[127:96], 1'b0);
    send_word(PT[95:64], 1'b0);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {s_axis_tready, en, busy, err}, 4'b0000);
    check("mid_rst_cmd", aes_cmd, 0);
    check("mid_rst_key", aes_key, 0);
    check("mid_rst_blk", aes_in_blk, 0);
    #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_frame(vecs[1], 10);

`ifdef AES_TLAST_CHECK_EN
    e0 = en_cnt;
    send_word(C_ENC, 1'b0);
    send_word(CT[127:96], 1'b0);
    send_word(CT[95:64], 1'b0);
    send_word(CT[63:32], 1'b1);
    check("early_tlast_err", err, 1);
    check("early_tlast_idle", {busy, s_axis_tready}, 2'b01);
    check("early_tlast_no_en", en_cnt - e0, 0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("early_tlast_clr", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
